pdua_ctrl_seq: RTL



---
 rtl/pdua_ctrl_pkg.sv | 73 +++++++
 rtl/pdua_ctrl_seq_if.sv | 30 +++
 rtl/pdua_ctrl_decode.sv | 98 +++++++++
 rtl/pdua_ctrl_seq.sv | 119 +++++++++++
 4 files changed

// File: rtl/pdua_ctrl_pkg.sv
// Shared types for the PDUA micro-sequencer: FSM states, opcodes, ALU codes
// and the packed control vector driven toward the datapath.
package pdua_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_F_MAR, S_F_RD, S_F_IR, S_F_PCINC, S_DECODE,
        S_EX_OP, S_EX_MAR, S_EX_RD, S_EX_WB, S_HALT, S_ILLEGAL
    } state_t;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_INC  = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b00101;
    localparam logic [4:0] OP_LDA  = 5'b00110;
    localparam logic [4:0] OP_STA  = 5'b00111;
    localparam logic [4:0] OP_JMP  = 5'b01000;
    localparam logic [4:0] OP_JZ   = 5'b01001;
    localparam logic [4:0] OP_JN   = 5'b01010;
    localparam logic [4:0] OP_JC   = 5'b01011;
    localparam logic [4:0] OP_SHL  = 5'b01100;
    localparam logic [4:0] OP_HALT = 5'b11111;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_NOT  = 3'b101;
    localparam logic [2:0] ALU_INC  = 3'b110;
    localparam logic [2:0] ALU_SHL  = 3'b111;

    // Bank addresses are parameters of the top, so the vector only names the register.
    typedef enum logic [1:0] {BUS_NONE, BUS_PC, BUS_ACC} bus_sel_t;

    typedef struct packed {
        logic       wr_rdn;
        logic       enaf;
        logic [2:0] selop;
        logic [1:0] shamt;
        logic       bank_wr_en;
        bus_sel_t   busb;
        bus_sel_t   busc;
        logic       sclr;
        logic       ir_en;
        logic       mar_en;
        logic       mdr_en;
        logic       mdr_alu_n;
    } ctrl_t;

    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c      = '0;
        c.sclr = 1'b1;
        return c;
    endfunction

    function automatic logic [2:0] alu_code(input logic [4:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_PASS;
        endcase
    endfunction

    function automatic logic is_jump(input logic [4:0] op);
        return (op == OP_JMP) || (op == OP_JZ) || (op == OP_JN) || (op == OP_JC);
    endfunction

endpackage

// File: rtl/pdua_ctrl_seq_if.sv
// Control/handshake bundle between the PDUA sequencer (master) and the
// datapath/system side (slave).
interface pdua_ctrl_seq_if #(
    parameter int ADDR_WIDTH = 3
);
    logic                  start;
    logic [4:0]            out_IR;
    logic                  C, N, P, Z;
    logic                  wr_rdn;
    logic                  enaf;
    logic [2:0]            selop;
    logic [1:0]            shamt;
    logic                  bank_wr_en;
    logic [ADDR_WIDTH-1:0] BusB_addr;
    logic [ADDR_WIDTH-1:0] BusC_addr;
    logic                  sclr, ir_en, mar_en, mdr_en, mdr_alu_n;
    logic                  busy, halted, illegal;

    modport master (
        input  start, out_IR, C, N, P, Z,
        output wr_rdn, enaf, selop, shamt, bank_wr_en, BusB_addr, BusC_addr,
               sclr, ir_en, mar_en, mdr_en, mdr_alu_n, busy, halted, illegal
    );

    modport slave (
        output start, out_IR, C, N, P, Z,
        input  wr_rdn, enaf, selop, shamt, bank_wr_en, BusB_addr, BusC_addr,
               sclr, ir_en, mar_en, mdr_en, mdr_alu_n, busy, halted, illegal
    );
endinterface

// File: rtl/pdua_ctrl_decode.sv
// Combinational map from (next) state, opcode and flags to the control vector.
// Conditional branches are honoured only with PDUA_CTRL_COND_BRANCH_EN.
module pdua_ctrl_decode
    import pdua_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       opnd_fetch,
    input  logic [4:0] opcode,
    input  logic [3:0] flags,      // {C, N, P, Z}
    output ctrl_t      ctrl
);

    logic taken;

`ifdef PDUA_CTRL_COND_BRANCH_EN
    logic unused_flag_p;
    assign unused_flag_p = flags[1];
    assign taken = (opcode == OP_JMP)
                || (opcode == OP_JZ && flags[0])
                || (opcode == OP_JN && flags[2])
                || (opcode == OP_JC && flags[3]);
`else
    logic unused_flags;
    assign unused_flags = ^flags;
    assign taken = (opcode == OP_JMP);
`endif

    // NOTE: every field gets a default before the case, so no path can infer a latch.
    always_comb begin
        ctrl = '0;
        case (state)
            S_IDLE:  ctrl = ctrl_idle();
            S_F_MAR: begin
                ctrl.busb   = BUS_PC;
                ctrl.selop  = ALU_PASS;
                ctrl.mar_en = 1'b1;
            end
            S_F_RD, S_EX_RD: ctrl.mdr_en = 1'b1;
            S_F_IR:  ctrl.ir_en = 1'b1;
            S_F_PCINC: begin
                ctrl.busb       = BUS_PC;
                ctrl.busc       = BUS_PC;
                ctrl.selop      = ALU_INC;
                ctrl.bank_wr_en = 1'b1;
            end
            S_EX_OP: begin
                ctrl.busb       = BUS_ACC;
                ctrl.busc       = BUS_ACC;
                ctrl.bank_wr_en = 1'b1;
                ctrl.enaf       = 1'b1;
                if (opcode == OP_SHL) begin
                    ctrl.selop = ALU_SHL;
                    ctrl.shamt = 2'b01;
                end else begin
                    ctrl.selop = ALU_INC;
                end
            end
            // First visit latches PC (operand address fetch), second latches MDR.
            S_EX_MAR: begin
                ctrl.mar_en = 1'b1;
                ctrl.selop  = ALU_PASS;
                if (opnd_fetch) ctrl.busb      = BUS_PC;
                else            ctrl.mdr_alu_n = 1'b1;
            end
            S_EX_WB: begin
                case (opcode)
                    OP_STA: begin
                        ctrl.busb   = BUS_ACC;
                        ctrl.mdr_en = 1'b1;
                        ctrl.wr_rdn = 1'b1;
                    end
                    OP_LDA: begin
                        ctrl.busc       = BUS_ACC;
                        ctrl.selop      = ALU_PASS;
                        ctrl.mdr_alu_n  = 1'b1;
                        ctrl.bank_wr_en = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        ctrl.busb       = BUS_ACC;
                        ctrl.busc       = BUS_ACC;
                        ctrl.selop      = alu_code(opcode);
                        ctrl.mdr_alu_n  = 1'b1;
                        ctrl.enaf       = 1'b1;
                        ctrl.bank_wr_en = 1'b1;
                    end
                    default: begin
                        ctrl.busc       = BUS_PC;
                        ctrl.selop      = ALU_PASS;
                        ctrl.mdr_alu_n  = 1'b1;
                        ctrl.bank_wr_en = taken;
                    end
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pdua_ctrl_seq.sv
// PDUA fetch/decode/execute micro-sequencer with registered control outputs.
// Define PDUA_CTRL_COND_BRANCH_EN to enable JZ/JN/JC; otherwise they are illegal.
module pdua_ctrl_seq
    import pdua_ctrl_pkg::*;
#(
    parameter int MAX_WIDTH  = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int PC_ADDR    = 0,
    parameter int ACC_ADDR   = 2**ADDR_WIDTH - 1
) (
    input  logic            clk,
    input  logic            rst,
    pdua_ctrl_seq_if.master bus
);

    localparam int unused_max_width = MAX_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PC_A  = ADDR_WIDTH'(PC_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ACC_A = ADDR_WIDTH'(ACC_ADDR);

    state_t state_q, state_d;
    logic   opnd_q, opnd_d;      // operand-address fetch in progress
    ctrl_t  ctrl_q, ctrl_d;
    logic   busy_q, halted_q, illegal_q;

    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        case (state_q)
            S_IDLE, S_HALT, S_ILLEGAL: begin
                if (bus.start) begin
                    state_d = S_F_MAR;
                    opnd_d  = 1'b0;
                end
            end
            S_F_MAR: state_d = S_F_RD;
            S_F_RD:  state_d = S_F_IR;
            S_F_IR:  state_d = S_F_PCINC;
            S_F_PCINC: begin
                if (opnd_q) begin
                    opnd_d  = 1'b0;
                    state_d = is_jump(bus.out_IR) ? S_EX_WB : S_EX_MAR;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (bus.out_IR)
                    OP_NOP:          state_d = S_F_MAR;
                    OP_INC, OP_SHL:  state_d = S_EX_OP;
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LDA, OP_STA, OP_JMP: begin
                        state_d = S_EX_MAR;
                        opnd_d  = 1'b1;
                    end
`ifdef PDUA_CTRL_COND_BRANCH_EN
                    OP_JZ, OP_JN, OP_JC: begin
                        state_d = S_EX_MAR;
                        opnd_d  = 1'b1;
                    end
`endif
                    OP_HALT:         state_d = S_HALT;
                    default:         state_d = S_ILLEGAL;
                endcase
            end
            S_EX_OP: state_d = S_F_MAR;
            // A store has nothing to read at the target address.
            S_EX_MAR: state_d = (!opnd_q && bus.out_IR == OP_STA) ? S_EX_WB : S_EX_RD;
            S_EX_RD:  state_d = opnd_q ? S_F_PCINC : S_EX_WB;
            S_EX_WB:  state_d = S_F_MAR;
            default:  state_d = S_IDLE;
        endcase
    end

    pdua_ctrl_decode u_decode (
        .state      (state_d),
        .opnd_fetch (opnd_d),
        .opcode     (bus.out_IR),
        .flags      ({bus.C, bus.N, bus.P, bus.Z}),
        .ctrl       (ctrl_d)
    );

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            opnd_q    <= 1'b0;
            ctrl_q    <= ctrl_idle();
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opnd_q    <= opnd_d;
            ctrl_q    <= ctrl_d;
            busy_q    <= !(state_d inside {S_IDLE, S_HALT, S_ILLEGAL});
            halted_q  <= (state_d == S_HALT) || (state_d == S_ILLEGAL);
            illegal_q <= (state_d == S_ILLEGAL);
        end
    end

    // Writes are masked during the reset cycle itself so no half-finished store lands.
    assign bus.wr_rdn     = ctrl_q.wr_rdn & ~rst;
    assign bus.bank_wr_en = ctrl_q.bank_wr_en & ~rst;
    assign bus.enaf       = ctrl_q.enaf;
    assign bus.selop      = ctrl_q.selop;
    assign bus.shamt      = ctrl_q.shamt;
    assign bus.BusB_addr  = (ctrl_q.busb == BUS_PC)  ? PC_A  :
                            (ctrl_q.busb == BUS_ACC) ? ACC_A : '0;
    assign bus.BusC_addr  = (ctrl_q.busc == BUS_PC)  ? PC_A  :
                            (ctrl_q.busc == BUS_ACC) ? ACC_A : '0;
    assign bus.sclr       = ctrl_q.sclr;
    assign bus.ir_en      = ctrl_q.ir_en;
    assign bus.mar_en     = ctrl_q.mar_en;
    assign bus.mdr_en     = ctrl_q.mdr_en;
    assign bus.mdr_alu_n  = ctrl_q.mdr_alu_n;
    assign bus.busy       = busy_q;
    assign bus.halted     = halted_q;
    assign bus.illegal    = illegal_q;

endmodule
